fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the team's synchronous FIFO between G_NUM_REQ producers.
- Each producer presents data with a valid/ready handshake.
- The arbiter grants one producer at a time for a bounded burst, honours FIFO full back-pressure, and drives the FIFO write enable and data.
- It sits directly in front of the FIFO write side, in the same clock domain.

---
 rtl/fifo_wr_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port
// between several valid/ready producers, with bounded bursts.
module fifo_wr_arbiter #(
   parameter int G_WIDTH     = 8,
   parameter int G_NUM_REQ   = 4,
   parameter int G_MAX_BURST = 4,
   localparam int IDW = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1,
   localparam int CW  = $clog2(G_MAX_BURST + 1)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [G_NUM_REQ-1:0]         i_req_valid,
   input  logic [G_NUM_REQ*G_WIDTH-1:0] i_req_data,
   output logic [G_NUM_REQ-1:0]         o_req_ready,
   input  logic                         i_fifo_full,
   output logic                         o_fifo_wr,
   output logic [G_WIDTH-1:0]           o_fifo_data,
   output logic [G_NUM_REQ-1:0]         o_grant,
   output logic [IDW-1:0]               o_grant_id,
   output logic                         o_busy
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BURST = 1'b1;

   localparam logic [IDW:0]   NREQ     = (IDW+1)'(G_NUM_REQ);
   localparam logic [IDW-1:0] LAST_ID  = IDW'(G_NUM_REQ - 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(G_MAX_BURST - 1);

   logic [0:0]           r_state;
   logic [IDW-1:0]       r_ptr;
   logic [IDW-1:0]       r_gnt_id;
   logic [CW-1:0]        r_cnt;

   logic                 found;
   logic [IDW-1:0]       sel_id;
   logic [IDW:0]         scan_idx;
   logic [IDW-1:0]       scan_id;
   logic [IDW-1:0]       nxt_ptr;
   logic [G_NUM_REQ-1:0] gnt_oh;
   logic                 busy;
   logic                 vld_g;
   logic                 rdy_g;
   logic                 xfer;

   // Scan from r_ptr with explicit wrap so non-power-of-two counts work
   always_comb begin
      found    = 1'b0;
      sel_id   = '0;
      scan_idx = '0;
      scan_id  = '0;
      for (int i = 0; i < G_NUM_REQ; i++) begin
         scan_idx = {1'b0, r_ptr} + (IDW+1)'(i);
         if (scan_idx >= NREQ)
            scan_idx = scan_idx - NREQ;
         scan_id = scan_idx[IDW-1:0];
         if (!found && i_req_valid[scan_id]) begin
            found  = 1'b1;
            sel_id = scan_id;
         end
      end
   end

   assign busy    = (r_state == S_BURST);
   assign gnt_oh  = busy ? (G_NUM_REQ'(1) << r_gnt_id) : '0;
   assign vld_g   = i_req_valid[r_gnt_id];
   assign rdy_g   = busy && !i_fifo_full && !i_rst;
   assign xfer    = rdy_g && vld_g;
   assign nxt_ptr = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + 1'b1;

   assign o_req_ready = rdy_g ? gnt_oh : '0;
   assign o_fifo_wr   = xfer;
   assign o_fifo_data = busy ?
      i_req_data[r_gnt_id*G_WIDTH +: G_WIDTH] : '0;
   assign o_grant     = gnt_oh;
   assign o_grant_id  = r_gnt_id;
   assign o_busy      = busy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_gnt_id <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (found) begin
                  r_gnt_id <= sel_id;
                  r_cnt    <= '0;
                  r_state  <= S_BURST;
               end
            end
            S_BURST: begin
               // A stalled but still-valid requester keeps its grant
               if (xfer && r_cnt == CNT_LAST) begin
                  r_state <= S_IDLE;
                  r_ptr   <= nxt_ptr;
               end else if (xfer) begin
                  r_cnt <= r_cnt + 1'b1;
               end else if (!vld_g) begin
                  r_state <= S_IDLE;
                  r_ptr   <= nxt_ptr;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: 4x4 and 3x1 configurations,
// producers advance their word on each accepted handshake.
module tb_fifo_wr_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, full_a, wr_a, busy_a;
   logic [3:0]  valid_a, ready_a, grant_a;
   logic [31:0] data_a;
   logic [7:0]  fdata_a;
   logic [1:0]  gid_a;

   logic        rst_b, full_b, wr_b, busy_b;
   logic [2:0]  valid_b, ready_b, grant_b;
   logic [23:0] data_b;
   logic [7:0]  fdata_b;
   logic [1:0]  gid_b;

   fifo_wr_arbiter #(.G_WIDTH(8), .G_NUM_REQ(4), .G_MAX_BURST(4)) u_a (
      .i_clk(clk), .i_rst(rst_a), .i_req_valid(valid_a),
      .i_req_data(data_a), .o_req_ready(ready_a),
      .i_fifo_full(full_a), .o_fifo_wr(wr_a), .o_fifo_data(fdata_a),
      .o_grant(grant_a), .o_grant_id(gid_a), .o_busy(busy_a));

   fifo_wr_arbiter #(.G_WIDTH(8), .G_NUM_REQ(3), .G_MAX_BURST(1)) u_b (
      .i_clk(clk), .i_rst(rst_b), .i_req_valid(valid_b),
      .i_req_data(data_b), .o_req_ready(ready_b),
      .i_fifo_full(full_b), .o_fifo_wr(wr_b), .o_fifo_data(fdata_b),
      .o_grant(grant_b), .o_grant_id(gid_b), .o_busy(busy_b));

   int n_chk = 0;
   int n_fail = 0;
   int cnt_a[4];
   int cnt_b[3];
   int sz;
   logic [7:0] qa[$];
   logic [7:0] qb[$];

   // FIFO-side capture; inputs are stable from +2ns to the next edge
   always @(negedge clk) begin
      if (wr_a) qa.push_back(fdata_a);
      if (wr_b) qb.push_back(fdata_b);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int k = 0; k < 4; k++)
         data_a[k*8 +: 8] = {4'(k), 4'(cnt_a[k])};
      for (int k = 0; k < 3; k++)
         data_b[k*8 +: 8] = {4'(k), 4'(cnt_b[k])};
   endtask

   task automatic tick();
      logic [3:0] xa;
      logic [2:0] xb;
      xa = ready_a & valid_a;
      xb = ready_b & valid_b;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (xa[k]) cnt_a[k]++;
      for (int k = 0; k < 3; k++) if (xb[k]) cnt_b[k]++;
      refresh();
      #1;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      full_a = 1'b0; full_b = 1'b0;
      valid_a = 4'hF; valid_b = 3'b000;
      for (int k = 0; k < 4; k++) cnt_a[k] = 0;
      for (int k = 0; k < 3; k++) cnt_b[k] = 0;
      refresh();
      tick();
      tick();
      chk("rst_busy", busy_a, 0);
      chk("rst_grant", grant_a, 0);
      chk("rst_gid", gid_a, 0);
      chk("rst_ready", ready_a, 0);
      chk("rst_wr", wr_a, 0);
      chk("rst_busy_b", busy_b, 0);

      // single requester 2, full burst then re-grant through wrap
      rst_a = 1'b0;
      valid_a = 4'b0100;
      #1;
      chk("t1_idle_busy", busy_a, 0);
      chk("t1_idle_wr", wr_a, 0);
      tick();
      chk("t1_grant", grant_a, 4'b0100);
      chk("t1_gid", gid_a, 2);
      chk("t1_ready", ready_a, 4'b0100);
      for (int k = 0; k < 4; k++) begin
         chk("t1_wr", wr_a, 1);
         chk("t1_data", fdata_a, 32'h20 + k);
         tick();
      end
      chk("t1_end_busy", busy_a, 0);
      chk("t1_end_wr", wr_a, 0);
      chk("t1_end_grant", grant_a, 0);
      tick();
      chk("t1_regrant_gid", gid_a, 2);
      chk("t1_regrant_wr", wr_a, 1);
      chk("t1_regrant_data", fdata_a, 8'h24);
      tick();
      valid_a = 4'b0000;
      #1;
      chk("t1_drop_wr", wr_a, 0);
      tick();
      chk("t1_drop_idle", busy_a, 0);
      chk("t1_nwrites", qa.size(), 5);

      // all requesters valid from pointer 0
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      for (int k = 0; k < 4; k++) cnt_a[k] = 0;
      refresh();
      qa.delete();
      valid_a = 4'hF;
      #1;
      for (int g = 0; g < 5; g++) begin
         chk("t2_idle", busy_a, 0);
         tick();
         for (int b = 0; b < 4; b++) begin
            chk("t2_grant", grant_a, 32'(1) << (g % 4));
            chk("t2_wr", wr_a, 1);
            chk("t2_data", fdata_a,
                ((g % 4) << 4) | ((g / 4) * 4 + b));
            tick();
         end
      end
      chk("t2_nwrites", qa.size(), 20);

      // requester 1 with a 3-cycle full stall after its 2nd write
      valid_a = 4'b0010;
      qa.delete();
      #1;
      tick();
      chk("t3_gid", gid_a, 1);
      chk("t3_d0", fdata_a, 8'h14);
      chk("t3_w0", wr_a, 1);
      tick();
      chk("t3_d1", fdata_a, 8'h15);
      tick();
      full_a = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("t3_full_ready", ready_a, 0);
         chk("t3_full_wr", wr_a, 0);
         chk("t3_full_busy", busy_a, 1);
         tick();
      end
      full_a = 1'b0;
      #1;
      chk("t3_w2", wr_a, 1);
      chk("t3_d2", fdata_a, 8'h16);
      tick();
      chk("t3_d3", fdata_a, 8'h17);
      tick();
      chk("t3_end_idle", busy_a, 0);
      chk("t3_nwrites", qa.size(), 4);
      chk("t3_q2", qa[2], 8'h16);
      chk("t3_q3", qa[3], 8'h17);

      // requester 3 forfeits after one write; requester 0 next
      valid_a = 4'b1001;
      #1;
      tick();
      chk("t4_gid", gid_a, 3);
      chk("t4_data", fdata_a, 8'h34);
      chk("t4_wr", wr_a, 1);
      tick();
      valid_a = 4'b0001;
      #1;
      chk("t4_drop_wr", wr_a, 0);
      chk("t4_drop_busy", busy_a, 1);
      tick();
      chk("t4_idle", busy_a, 0);
      tick();
      chk("t4_grant0", grant_a, 4'b0001);
      chk("t4_data0", fdata_a, 8'h08);

      // reset during requester 1's third write
      valid_a = 4'b0010;
      #1;
      tick();
      chk("t5_idle", busy_a, 0);
      tick();
      chk("t5_gid", gid_a, 1);
      chk("t5_w0", wr_a, 1);
      tick();
      chk("t5_w1", wr_a, 1);
      tick();
      rst_a = 1'b1;
      #1;
      chk("t5_rst_ready", ready_a, 0);
      chk("t5_rst_wr", wr_a, 0);
      sz = qa.size();
      tick();
      rst_a = 1'b0;
      valid_a = 4'b0011;
      #1;
      chk("t5_after_busy", busy_a, 0);
      chk("t5_after_grant", grant_a, 0);
      chk("t5_no_write", qa.size(), sz);
      tick();
      chk("t5_regrant0", grant_a, 4'b0001);

      // 3 requesters, burst of 1
      rst_b = 1'b0;
      valid_b = 3'b111;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("t6_idle_busy", busy_b, 0);
         chk("t6_idle_wr", wr_b, 0);
         tick();
         chk("t6_gid", gid_b, i % 3);
         chk("t6_wr", wr_b, 1);
         tick();
      end
      chk("t6_nwrites", qb.size(), 4);
      chk("t6_q0", qb[0], 8'h00);
      chk("t6_q1", qb[1], 8'h10);
      chk("t6_q2", qb[2], 8'h20);
      chk("t6_q3", qb[3], 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
